// File: rtl/pl_mem_arb_pkg.sv
// Shared types for the pipelined memory arbiter: request source tags and arbiter FSM states.
package pl_mem_arb_pkg;

  typedef enum logic {SRC_INST, SRC_DATA} mem_src_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_INST, ARB_LOCK_DATA} arb_state_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pl_mem_arb_order_fifo.sv
// Order queue of outstanding read sources; head names the requester that owns the next response.
module pl_mem_arb_order_fifo
  import pl_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        push,
  input  mem_src_t                    push_src,
  input  logic                        pop,
  output mem_src_t                    head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned PtrW = ptr_width(DEPTH);

  mem_src_t            slots_q [DEPTH];
  mem_src_t            slots_d [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push_en, pop_en;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = slots_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      slots_d[wr_ptr_q] = push_src;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slots_q[i] <= SRC_INST;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slots_q  <= slots_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pl_memory_arbiter.sv
// Round-robin arbiter sharing one pipelined memory port between instruction fetch and data access;
// grant is frozen while the memory stalls and read responses are routed back in issue order.
module pl_memory_arbiter
  import pl_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inst_read_enable,
  input  logic [31:0] inst_addr,
  output logic        inst_wait_req,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  input  logic        data_read_enable,
  input  logic        data_write_enable,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_byte_enable,
  output logic        data_wait_req,
  output logic        data_valid,
  output logic [31:0] data_read_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic        mem_wait_req,
  input  logic        mem_valid,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CntW = cnt_width(MAX_PENDING);

  arb_state_t      state_q, state_d;
  mem_src_t        last_grant_q, last_grant_d;
  logic            inst_req, data_req, data_is_wr;
  logic            read_block, inst_ok, data_ok;
  logic            grant_vld;
  mem_src_t        grant_src;
  logic            accepted, push;
  logic [CntW-1:0] q_count;
  logic            q_full, q_empty;
  mem_src_t        q_head;

  assign inst_req   = inst_read_enable;
  assign data_req   = data_read_enable | data_write_enable;
  assign data_is_wr = data_write_enable;

  // Full check uses the registered count only; a same-cycle response does not free a slot.
  assign read_block = (q_count == CntW'(MAX_PENDING));
  assign inst_ok    = inst_req & ~read_block;
  assign data_ok    = data_req & (data_is_wr | ~read_block);

  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_INST;
    unique case (state_q)
      ARB_IDLE: begin
        if (inst_ok && data_ok) begin
          grant_vld = 1'b1;
          grant_src = (last_grant_q == SRC_INST) ? SRC_DATA : SRC_INST;
        end else if (inst_ok) begin
          grant_vld = 1'b1;
          grant_src = SRC_INST;
        end else if (data_ok) begin
          grant_vld = 1'b1;
          grant_src = SRC_DATA;
        end
      end
      ARB_LOCK_INST: begin
        grant_vld = inst_ok;
        grant_src = SRC_INST;
      end
      ARB_LOCK_DATA: begin
        grant_vld = data_ok;
        grant_src = SRC_DATA;
      end
      default: begin
        grant_vld = 1'b0;
        grant_src = SRC_INST;
      end
    endcase
  end

  always_comb begin
    mem_read_enable  = grant_vld & ((grant_src == SRC_INST) | ~data_is_wr);
    mem_write_enable = grant_vld & (grant_src == SRC_DATA) & data_is_wr;
    mem_address      = (grant_src == SRC_INST) ? inst_addr : data_addr;
    mem_byte_enable  = (grant_src == SRC_INST) ? 4'b1111 : data_byte_enable;
    mem_write_data   = data_write_data;
    accepted         = (mem_read_enable | mem_write_enable) & ~mem_wait_req;
    push             = accepted & mem_read_enable;
    inst_wait_req    = inst_req & ~(accepted & (grant_src == SRC_INST));
    data_wait_req    = data_req & ~(accepted & (grant_src == SRC_DATA));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = accepted ? grant_src : last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_vld && mem_wait_req) begin
          state_d = (grant_src == SRC_INST) ? ARB_LOCK_INST : ARB_LOCK_DATA;
        end
      end
      ARB_LOCK_INST, ARB_LOCK_DATA: begin
        // A locked side withdrawing its request also releases the lock.
        if (!grant_vld || accepted) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= SRC_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  pl_mem_arb_order_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_order_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_src (grant_src),
    .pop      (mem_valid),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign inst_valid     = mem_valid & ~q_empty & (q_head == SRC_INST);
  assign data_valid     = mem_valid & ~q_empty & (q_head == SRC_DATA);
  assign inst_data      = mem_read_data;
  assign data_read_data = mem_read_data;

  push_never_when_full: assert property (@(posedge clock) disable iff (!reset_n) !(push && q_full));

endmodule

// File: tb/tb_pl_memory_arbiter.sv
// Directed bench for pl_memory_arbiter with hand-computed expectations.
module tb_pl_memory_arbiter;

  logic        clock;
  logic        reset_n;
  logic        inst_read_enable;
  logic [31:0] inst_addr;
  logic        inst_wait_req;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        data_read_enable;
  logic        data_write_enable;
  logic [31:0] data_addr;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic        data_wait_req;
  logic        data_valid;
  logic [31:0] data_read_data;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_wait_req;
  logic        mem_valid;
  logic [31:0] mem_read_data;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  pl_memory_arbiter #(
    .MAX_PENDING (4)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .inst_read_enable  (inst_read_enable),
    .inst_addr         (inst_addr),
    .inst_wait_req     (inst_wait_req),
    .inst_valid        (inst_valid),
    .inst_data         (inst_data),
    .data_read_enable  (data_read_enable),
    .data_write_enable (data_write_enable),
    .data_addr         (data_addr),
    .data_write_data   (data_write_data),
    .data_byte_enable  (data_byte_enable),
    .data_wait_req     (data_wait_req),
    .data_valid        (data_valid),
    .data_read_data    (data_read_data),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_byte_enable   (mem_byte_enable),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .mem_wait_req      (mem_wait_req),
    .mem_valid         (mem_valid),
    .mem_read_data     (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_in();
    inst_read_enable  = 1'b0;
    inst_addr         = '0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    data_addr         = '0;
    data_write_data   = '0;
    data_byte_enable  = '0;
    mem_wait_req      = 1'b0;
    mem_valid         = 1'b0;
    mem_read_data     = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, mem_read_enable, 0);
    check({tag, "_wr_en"}, mem_write_enable, 0);
    check({tag, "_ivalid"}, inst_valid, 0);
    check({tag, "_dvalid"}, data_valid, 0);
    check({tag, "_iwait"}, inst_wait_req, 0);
    check({tag, "_dwait"}, data_wait_req, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    #12;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    next_cycle();

    // Single instruction read, response two cycles later
    inst_read_enable = 1'b1;
    inst_addr        = 32'h100;
    #1;
    check("a_rd_en", mem_read_enable, 1);
    check("a_wr_en", mem_write_enable, 0);
    check("a_addr", mem_address, 32'h100);
    check("a_be", mem_byte_enable, 4'hF);
    check("a_iwait", inst_wait_req, 0);
    next_cycle();
    inst_read_enable = 1'b0;
    next_cycle();
    mem_valid     = 1'b1;
    mem_read_data = 32'hDEADBEEF;
    #1;
    check("a_ivalid", inst_valid, 1);
    check("a_idata", inst_data, 32'hDEADBEEF);
    check("a_dvalid", data_valid, 0);
    next_cycle();
    mem_valid = 1'b0;

    // Both sides streaming reads after reset: inst wins first tie, then alternate
    do_reset();
    inst_read_enable = 1'b1;
    inst_addr        = 32'h1000;
    data_read_enable = 1'b1;
    data_addr        = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b_addr", mem_address, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      check("b_iwait", inst_wait_req, (i % 2 == 0) ? 0 : 1);
      check("b_dwait", data_wait_req, (i % 2 == 0) ? 1 : 0);
      next_cycle();
    end
    #1;
    check("b_full_rd_en", mem_read_enable, 0);
    check("b_full_iwait", inst_wait_req, 1);
    check("b_full_dwait", data_wait_req, 1);
    inst_read_enable = 1'b0;
    data_read_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid     = 1'b1;
      mem_read_data = 32'hA0 + i;
      #1;
      check("b_ivalid", inst_valid, (i % 2 == 0) ? 1 : 0);
      check("b_dvalid", data_valid, (i % 2 == 0) ? 0 : 1);
      check("b_rdata", (i % 2 == 0) ? inst_data : data_read_data, 32'hA0 + i);
      next_cycle();
    end
    mem_valid = 1'b0;

    // Make inst the last grant so the data write wins the next tie
    inst_read_enable = 1'b1;
    inst_addr        = 32'h300;
    next_cycle();
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    mem_read_data    = 32'h55;
    #1;
    check("c_pre_ivalid", inst_valid, 1);
    next_cycle();
    mem_valid = 1'b0;

    // Stalled data write holds the port for 4 cycles
    data_write_enable = 1'b1;
    data_addr         = 32'h200;
    data_byte_enable  = 4'b0011;
    data_write_data   = 32'h12345678;
    inst_read_enable  = 1'b1;
    inst_addr         = 32'h300;
    mem_wait_req      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_wait_req = 1'b0;
      #1;
      check("c_wr_en", mem_write_enable, 1);
      check("c_rd_en", mem_read_enable, 0);
      check("c_addr", mem_address, 32'h200);
      check("c_be", mem_byte_enable, 4'b0011);
      check("c_wdata", mem_write_data, 32'h12345678);
      check("c_iwait", inst_wait_req, 1);
      check("c_dwait", data_wait_req, (i < 3) ? 1 : 0);
      next_cycle();
    end
    data_write_enable = 1'b0;
    #1;
    check("c_after_rd_en", mem_read_enable, 1);
    check("c_after_addr", mem_address, 32'h300);
    check("c_after_iwait", inst_wait_req, 0);
    next_cycle();
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    mem_read_data    = 32'h77;
    #1;
    check("c_ivalid", inst_valid, 1);
    check("c_idata", inst_data, 32'h77);
    next_cycle();
    mem_valid = 1'b0;

    // Fill the queue with 4 inst reads; 5th is blocked but a write still goes
    inst_read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h400 + 32'(4 * i);
      #1;
      check("d_iwait", inst_wait_req, 0);
      next_cycle();
    end
    data_write_enable = 1'b1;
    data_addr         = 32'h500;
    #1;
    check("d_blk_rd_en", mem_read_enable, 0);
    check("d_blk_iwait", inst_wait_req, 1);
    check("d_wr_en", mem_write_enable, 1);
    check("d_wr_addr", mem_address, 32'h500);
    check("d_dwait", data_wait_req, 0);
    next_cycle();
    data_write_enable = 1'b0;
    mem_valid         = 1'b1;
    mem_read_data     = 32'h99;
    #1;
    check("d_pop_ivalid", inst_valid, 1);
    check("d_pop_rd_en", mem_read_enable, 0);
    check("d_pop_iwait", inst_wait_req, 1);
    next_cycle();
    mem_valid = 1'b0;
    #1;
    check("d_issue_rd_en", mem_read_enable, 1);
    check("d_issue_iwait", inst_wait_req, 0);
    check("d_issue_addr", mem_address, 32'h40C);
    next_cycle();
    inst_read_enable = 1'b0;

    // Drain two, then reset with two outstanding
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1;
      #1;
      check("e_drain_ivalid", inst_valid, 1);
      next_cycle();
    end
    mem_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_reset_outputs("e_rst");
    #1;
    reset_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      mem_valid     = 1'b1;
      mem_read_data = 32'hBAD0 + i;
      #1;
      check("e_stale_ivalid", inst_valid, 0);
      check("e_stale_dvalid", data_valid, 0);
      next_cycle();
    end
    mem_valid = 1'b0;

    // Count stayed 0: exactly 4 reads fit before blocking
    inst_read_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_addr = 32'h600 + 32'(4 * i);
      #1;
      check("f_iwait", inst_wait_req, (i == 4) ? 1 : 0);
      next_cycle();
    end
    inst_read_enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pl_memory_arbiter.md
# pl_memory_arbiter

- Shares one pipelined memory port (wait-request / read-valid protocol) between the instruction-fetch side and the data-access side of the pipelined core.
- Picks one requester per accepted transfer with round-robin fairness and holds the grant while the memory stalls.
- Records the source of every outstanding read in an order queue, so in-order read responses go back to the right requester.
- Sits between the text memory interface, the data memory interface and the single external memory.

## Interface
- MAX_PENDING, 4: maximum outstanding reads; order queue depth (≥1).
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inst_read_enable  in  1  instruction read request.
- inst_addr  in  32  instruction address.
- inst_wait_req  out  1  instruction request not accepted this cycle.
- inst_valid  out  1  instruction read response valid.
- inst_data  out  32  instruction read data.
- data_read_enable  in  1  data read request.
- data_write_enable  in  1  data write request.
- data_addr  in  32  data address.
- data_write_data  in  32  write data.
- data_byte_enable  in  4  byte lanes.
- data_wait_req  out  1  data request not accepted this cycle.
- data_valid  out  1  data read response valid.
- data_read_data  out  32  data read data.
- mem_address / mem_write_data  out  32  to memory.
- mem_byte_enable  out  4  to memory (4'b1111 for instruction reads).
- mem_read_enable / mem_write_enable  out  1  to memory.
- mem_wait_req  in  1  memory stall.
- mem_valid  in  1  read response valid.
- mem_read_data  in  32  read response data.

## Operation
- Request classes:
  - inst req = inst_read_enable.
  - data req = data_read_enable | data_write_enable.
  - data with both enables set is a write.
- FSM states:
  - IDLE: grant computed combinationally.
  - LOCK_INST / LOCK_DATA: grant frozen.
- IDLE transitions:
  - Only one side requests: grant it.
  - Both request: grant the side opposite last_grant.
  - Granted transfer stalled (mem_wait_req=1): go to LOCK_<side>.
- LOCK transitions:
  - Mem inputs follow the locked side.
  - Return to IDLE on the cycle the transfer is accepted.
  - Locked side dropping its request (protocol violation): return to IDLE, no transfer issued.
- last_grant: updated only on acceptance; reset value SRC_DATA, so the instruction side wins the first tie.
- Read blocking: a read (either side) is blocked when count == MAX_PENDING.
  - Blocked read is not issued: mem_read_enable=0.
  - The blocked side gets wait_req=1.
  - The other side may be granted that cycle.
  - Writes are never blocked by the queue.
- Acceptance = mem_*_enable & !mem_wait_req.
  - Accepted read pushes source (SRC_INST/SRC_DATA) into the queue.
  - Accepted write pushes nothing.
- Requester wait_req: X_wait_req = X req & !(granted to X & accepted). Idle requester sees 0.
- Responses:
  - mem_valid pops the queue head.
  - Head source's *_valid is asserted; mem_read_data is forwarded to its data output.
- mem_valid with empty queue: ignored, no valid asserted, no pointer change.
- Occupancy: count has width $clog2(MAX_PENDING+1).
  - Push and pop in the same cycle: count unchanged.
  - Read pointers wrap modulo MAX_PENDING.
  - The full check uses registered count, with no pop bypass.
- Reset (asserted at any time, including mid-transfer):
  - Queue emptied; FSM to IDLE; last_grant=SRC_DATA.
  - Responses arriving after reset for pre-reset reads are dropped (empty-queue rule).

## Timing
- Request path is zero latency: mem_* and *_wait_req are combinational from requester inputs, FSM state, last_grant and count.
- Response path is zero latency: *_valid / *_data are combinational from mem_valid, mem_read_data and queue head.
- Outputs during reset with all requests low: mem_read_enable=0, mem_write_enable=0, inst_valid=0, data_valid=0, inst_wait_req=0, data_wait_req=0.
- Throughput: one accepted transfer per cycle when the memory does not stall.
- Arbitration with both sides streaming: alternates per accepted transfer.

## Structure
- Package pl_mem_arb_pkg holds:
  - typedef enum logic {SRC_INST, SRC_DATA} mem_src_t;
  - typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_INST, ARB_LOCK_DATA} arb_state_t.
- Sub-module pl_mem_arb_order_fifo:
  - parameter DEPTH; mem_src_t storage.
  - push, pop, head, count, full, empty.
  - Asynchronous active-low reset.
- Top level contains the FSM, last_grant, muxing and response routing.

## Test plan
- Inst-only read at 0x100, mem_wait_req=0 → mem_read_enable=1 and mem_address=0x100 same cycle; mem_valid with 0xDEADBEEF two cycles later → inst_valid=1, inst_data=0xDEADBEEF, data_valid=0.
- Both sides read continuously after reset, no stall → grants inst, data, inst, data; responses routed in issue order.
- Data write 0x200 / be 4'b0011 stalled 3 cycles while inst requests → mem_* held to data write for all 4 cycles; inst_wait_req=1; inst granted the cycle after acceptance.
- MAX_PENDING=4, 4 inst reads issued with no responses → 5th read sees inst_wait_req=1 and mem_read_enable=0; a concurrent data write is still accepted; one mem_valid → the read issues the next cycle.
- Reset_n pulsed low with 2 reads outstanding → all outputs at reset values immediately; 2 later mem_valid pulses produce no inst_valid or data_valid.
- mem_valid with empty queue → no valid asserted; count stays 0.
